// File: rtl/vid_pattern_gen.sv
// -----------------------------------------------------------------------------
// vid_pattern_gen
//   Video timing and test-pattern source. It generates VGA-style raster timing
//   and a 24-bit {R,G,B} pixel stream. It stands in for the live camera/HDMI
//   input during bring-up.
//
//   Ports
//     clk        pixel clock
//     rst        asynchronous reset, active-high
//     en         run enable; low holds the raster at the origin with idle outputs
//     pattern_i  0 colour bars, 1 horizontal gradient, 2 checkerboard, 3 solid
//     color_i    solid colour used by pattern 3, {R,G,B}
//     data_o     pixel {R,G,B}; zero outside the active area
//     vde_o      active video
//     hsync_o    horizontal sync, active level HS_POL
//     vsync_o    vertical sync, active level VS_POL
//     sof_o      single-cycle pulse on the first active pixel of each frame
//
//   The build option VID_PATTERN_SCROLL_EN enables an 8-bit frame counter.
//   That counter is added to the horizontal coordinate of patterns 0-2, so the
//   image scrolls left by one pixel per frame. When the option is not defined,
//   the patterns are static and there is no frame counter.
//
//   All outputs are registered and mutually aligned. They lag the raster
//   counters by one cycle.
// -----------------------------------------------------------------------------
module vid_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_i,
  input  logic [23:0] color_i,
  output logic [23:0] data_o,
  output logic        vde_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        sof_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BP_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [H_W-1:0]  H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]  H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]  H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]  H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]  V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]  V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]  V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]  V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BP_W-1:0] BAR_LAST   = BP_W'(BAR_W - 1);

  // Raster counters
  logic [H_W-1:0] h_cnt_reg, h_cnt_next;
  logic [V_W-1:0] v_cnt_reg, v_cnt_next;
  logic           line_end, frame_end, frame_start;

  // Bar position tracked incrementally along the line, so no divider is needed
  logic [2:0]      bar_idx_reg, bar_idx_next;
  logic [BP_W-1:0] bar_px_reg, bar_px_next;

  // Bar position loaded at the start of each line (non-zero only when scrolling)
  logic [2:0]      start_idx_next;
  logic [BP_W-1:0] start_px_next;
  logic [7:0]      offset8;

  // Pattern selection latched once per frame
  logic [1:0]  pattern_reg, pattern_eff;
  logic [23:0] color_reg, color_eff;

  logic [7:0]  h_lo8, hx8;
  logic [23:0] pix;
  logic        active, hs_act, vs_act;

  assign line_end    = (h_cnt_reg == H_LAST);
  assign frame_end   = line_end && (v_cnt_reg == V_LAST);
  assign frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);

  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (line_end) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end
  end

`ifdef VID_PATTERN_SCROLL_EN
  // The frame counter is the scroll offset. The line-start bar position follows
  // it modulo H_ACTIVE one step per frame. Both return to zero when the counter
  // wraps 255 -> 0.
  logic [7:0]      frame_cnt_reg;
  logic [2:0]      start_idx_reg;
  logic [BP_W-1:0] start_px_reg;

  always_comb begin
    start_idx_next = start_idx_reg;
    start_px_next  = start_px_reg;
    if (frame_end) begin
      if (frame_cnt_reg == 8'hFF) begin
        start_idx_next = '0;
        start_px_next  = '0;
      end else if (start_px_reg == BAR_LAST) begin
        start_px_next  = '0;
        start_idx_next = start_idx_reg + 3'd1;  // 7 -> 0 wraps modulo H_ACTIVE
      end else begin
        start_px_next  = start_px_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      start_idx_reg <= '0;
      start_px_reg  <= '0;
    end else if (!en) begin
      frame_cnt_reg <= '0;
      start_idx_reg <= '0;
      start_px_reg  <= '0;
    end else begin
      if (frame_end) frame_cnt_reg <= frame_cnt_reg + 8'd1;
      start_idx_reg <= start_idx_next;
      start_px_reg  <= start_px_next;
    end
  end

  assign offset8 = frame_cnt_reg;
`else
  assign start_idx_next = '0;
  assign start_px_next  = '0;
  assign offset8        = 8'd0;
`endif

  always_comb begin
    bar_idx_next = bar_idx_reg;
    bar_px_next  = bar_px_reg;
    if (line_end) begin
      bar_idx_next = start_idx_next;
      bar_px_next  = start_px_next;
    end else if (bar_px_reg == BAR_LAST) begin
      bar_px_next  = '0;
      bar_idx_next = bar_idx_reg + 3'd1;
    end else begin
      bar_px_next  = bar_px_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      bar_idx_reg <= '0;
      bar_px_reg  <= '0;
    end else if (!en) begin
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      bar_idx_reg <= '0;
      bar_px_reg  <= '0;
    end else begin
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
      bar_idx_reg <= bar_idx_next;
      bar_px_reg  <= bar_px_next;
    end
  end

  // The first pixel of a frame uses the inputs directly. The rest of the frame
  // uses the copy latched at that same edge.
  assign pattern_eff = frame_start ? pattern_i : pattern_reg;
  assign color_eff   = frame_start ? color_i   : color_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_reg <= '0;
      color_reg   <= '0;
    end else if (en && frame_start) begin
      pattern_reg <= pattern_i;
      color_reg   <= color_i;
    end
  end

  // Colour-bar table. Each bar index maps to R = ~idx[1], G = ~idx[2],
  // B = ~idx[0], giving white, yellow, cyan, green, magenta, red, blue, black.
  logic [23:0] bar_lut [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_bar_lut
    localparam logic [2:0] IDX = 3'(gi);
    assign bar_lut[gi] = {{8{~IDX[1]}}, {8{~IDX[2]}}, {8{~IDX[0]}}};
  end

  assign h_lo8 = 8'(h_cnt_reg);
  assign hx8   = h_lo8 + offset8;

  always_comb begin
    pix = '0;
    case (pattern_eff)
      2'd0:    pix = bar_lut[bar_idx_reg];
      2'd1:    pix = {hx8, hx8, hx8};
      2'd2:    pix = (hx8[5] ^ v_cnt_reg[5]) ? 24'h000000 : 24'hFFFFFF;
      default: pix = color_eff;
    endcase
  end

  assign active = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hs_act = (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
  assign vs_act = (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o  <= '0;
      vde_o   <= 1'b0;
      hsync_o <= ~HS_POL;
      vsync_o <= ~VS_POL;
      sof_o   <= 1'b0;
    end else if (!en) begin
      data_o  <= '0;
      vde_o   <= 1'b0;
      hsync_o <= ~HS_POL;
      vsync_o <= ~VS_POL;
      sof_o   <= 1'b0;
    end else begin
      data_o  <= active ? pix : 24'h000000;
      vde_o   <= active;
      hsync_o <= hs_act ? HS_POL : ~HS_POL;
      vsync_o <= vs_act ? VS_POL : ~VS_POL;
      sof_o   <= frame_start;
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vid_pattern_gen
//   Bench for vid_pattern_gen. It uses a reduced raster so that several whole
//   frames fit in a short run. A behavioural model tracks the raster position
//   and computes every expected pixel arithmetically. Directed steps cover
//   reset, sync counts, pattern values, frame-boundary pattern latching, enable
//   drop and asynchronous reset. Randomised pattern, colour and enable changes
//   follow those steps.
// -----------------------------------------------------------------------------
module tb_vid_pattern_gen;

  localparam int HA  = 128;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int VA  = 40;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pattern_i;
  logic [23:0] color_i;
  logic [23:0] data_o;
  logic        vde_o, hsync_o, vsync_o, sof_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: raster position at the next edge, frame number, latched selection
  int          m_h, m_v, m_frame;
  logic [1:0]  m_pat;
  logic [23:0] m_col;

  int hs_low, vde_n, vs_low, sof_n;

  vid_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_i(pattern_i), .color_i(color_i),
    .data_o(data_o), .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .sof_o(sof_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {4'b0, data_o, vde_o, hsync_o, vsync_o, sof_o};
  endfunction

  function automatic logic [31:0] idle_vec();
    return {4'b0, 24'h000000, 1'b0, ~HS_POL, ~VS_POL, 1'b0};
  endfunction

  function automatic int scroll_off();
`ifdef VID_PATTERN_SCROLL_EN
    return m_frame;
`else
    return 0;
`endif
  endfunction

  function automatic logic [23:0] px_model(int h, int v, logic [1:0] pat,
                                           logic [23:0] col, int off);
    int x;
    logic [7:0] g;
    if (h >= HA || v >= VA) return 24'h000000;
    x = h + off;
    case (pat)
      2'd0: return BARS[(x % HA) / (HA / 8)];
      2'd1: begin g = 8'(x % 256); return {g, g, g}; end
      2'd2: return ((((x / 32) % 2) ^ ((v / 32) % 2)) == 0) ? 24'hFFFFFF : 24'h000000;
      default: return col;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                     input bit show);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    if (show) $display("[TB] %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_frame = 0; m_pat = 2'd0; m_col = 24'h0;
  endtask

  task automatic clear_acc();
    hs_low = 0; vde_n = 0; vs_low = 0; sof_n = 0;
  endtask

  // One clock. The expected outputs come from the model state and inputs before
  // the edge. The DUT outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic [31:0] expv;
    logic [23:0] ed;
    logic ev, ehs, evs, esof;
    if (rst || !en) begin
      expv = idle_vec();
    end else begin
      if (m_h == 0 && m_v == 0) begin
        m_pat = pattern_i;
        m_col = color_i;
      end
      ev   = (m_h < HA) && (m_v < VA);
      ehs  = (m_h >= HA + HFP && m_h < HA + HFP + HS) ? HS_POL : ~HS_POL;
      evs  = (m_v >= VA + VFP && m_v < VA + VFP + VS) ? VS_POL : ~VS_POL;
      esof = (m_h == 0 && m_v == 0);
      ed   = px_model(m_h, m_v, m_pat, m_col, scroll_off());
      expv = {4'b0, ed, ev, ehs, evs, esof};
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (!en) begin
      m_h = 0; m_v = 0; m_frame = 0;
    end else begin
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) begin
          m_v = 0;
          m_frame = (m_frame + 1) % 256;
        end
      end
    end
    chk("pixel", outs(), expv, 1'b0);
    if (hsync_o == HS_POL) hs_low++;
    if (vsync_o == VS_POL) vs_low++;
    if (vde_o) vde_n++;
    if (sof_o) sof_n++;
  endtask

  // Advance until the outputs show raster position (h, v)
  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(m_h == h && m_v == v) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (n >= 2 * FRAME) begin
      tests_run++;
      tests_failed++;
      $error("FAIL run_to_timeout observed=%0d,%0d expected=%0d,%0d", m_h, m_v, h, v);
    end
    tick();
  endtask

  logic [23:0] cap0;

  initial begin
    rst = 1'b1; en = 1'b1; pattern_i = 2'd0; color_i = 24'h0;
    model_reset();
    clear_acc();

    // Reset held with enable high: outputs stay idle
    repeat (6) tick();
    chk("rst_idle", outs(), idle_vec(), 1'b1);

    // One full frame of colour bars: sync and active-video counts
    rst = 1'b0;
    clear_acc();
    repeat (FRAME) tick();
    chk("hs_low_cnt", 32'(hs_low), 32'(HS * VT), 1'b1);
    chk("vde_cnt", 32'(vde_n), 32'(HA * VA), 1'b1);
    chk("vs_low_cnt", 32'(vs_low), 32'(VS * HT), 1'b1);
    chk("sof_cnt", 32'(sof_n), 32'd1, 1'b1);

    // Bar boundaries (bars are HA/8 = 16 px wide here)
    run_to(0, 0);
`ifndef VID_PATTERN_SCROLL_EN
    chk("bar_px0", 32'(data_o), 32'h00FFFFFF, 1'b1);
`endif
    chk("sof_px0", 32'(sof_o), 32'd1, 1'b1);
    run_to(16, 0);
`ifndef VID_PATTERN_SCROLL_EN
    chk("bar_px16", 32'(data_o), 32'h00FFFF00, 1'b1);
`endif
    run_to(96, 0);
`ifndef VID_PATTERN_SCROLL_EN
    chk("bar_px96", 32'(data_o), 32'h000000FF, 1'b1);
`endif
    run_to(127, 0);
    chk("bar_px127", 32'(data_o), 32'h00000000, 1'b1);
    run_to(HA, 0);
    chk("blank_px", {7'b0, data_o, vde_o}, 32'h0, 1'b1);

    // Mid-frame pattern changes take effect at the next frame
    run_to(50, 10);
    pattern_i = 2'd1;
    run_to(0, 20);
`ifndef VID_PATTERN_SCROLL_EN
    chk("still_bars", 32'(data_o), 32'h00FFFFFF, 1'b1);
`endif
    run_to(20, 5);
`ifndef VID_PATTERN_SCROLL_EN
    chk("gradient20", 32'(data_o), 32'h00141414, 1'b1);
`endif
    run_to(60, 30);
    pattern_i = 2'd3;
    color_i   = 24'h123456;
    run_to(70, 35);
`ifndef VID_PATTERN_SCROLL_EN
    chk("still_grad", 32'(data_o), 32'h00464646, 1'b1);
`endif
    run_to(5, 3);
    chk("solid", 32'(data_o), 32'h00123456, 1'b1);

    // Checkerboard
    pattern_i = 2'd2;
    run_to(0, 0);
    run_to(40, 0);
`ifndef VID_PATTERN_SCROLL_EN
    chk("check_40_0", 32'(data_o), 32'h00000000, 1'b1);
`endif
    run_to(10, 33);
`ifndef VID_PATTERN_SCROLL_EN
    chk("check_10_33", 32'(data_o), 32'h00000000, 1'b1);
`endif
    run_to(40, 33);
`ifndef VID_PATTERN_SCROLL_EN
    chk("check_40_33", 32'(data_o), 32'h00FFFFFF, 1'b1);
`endif

    // Randomised pattern, colour and enable changes against the model
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ($urandom_range(0, 4999) == 0) pattern_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4999) == 0) color_i = 24'($urandom);
      if (!en) en = 1'b1;
      else if ($urandom_range(0, 4999) == 0) en = 1'b0;
      tick();
    end
    en = 1'b1;

    // Enable drop mid-frame, then restart from the origin
    pattern_i = 2'd0;
    run_to(30, 20);
    en = 1'b0;
    tick();
    chk("en_low_idle", outs(), idle_vec(), 1'b1);
    repeat (3) tick();
    en = 1'b1;
    tick();
    chk("restart_sof", 32'(sof_o), 32'd1, 1'b1);
    chk("restart_px", 32'(data_o), 32'h00FFFFFF, 1'b1);

    // Asynchronous reset mid-line: outputs idle without a clock edge
    pattern_i = 2'd3;
    color_i   = 24'hA5C3E1;
    run_to(0, 0);
    run_to(10, 5);
    chk("pre_rst_px", 32'(data_o), 32'h00A5C3E1, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst", outs(), idle_vec(), 1'b1);
    model_reset();
    pattern_i = 2'd1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_sof", 32'(sof_o), 32'd1, 1'b1);

`ifdef VID_PATTERN_SCROLL_EN
    // Scrolling: frame 3 pixel 0 matches frame 0 pixel 3
    run_to(3, 0);
    cap0 = data_o;
    chk("scroll_f0p3", 32'(cap0), 32'h00030303, 1'b1);
    run_to(0, 0);
    run_to(0, 0);
    run_to(0, 0);
    chk("scroll_f3p0", 32'(data_o), 32'(cap0), 1'b1);
`else
    run_to(3, 0);
    cap0 = data_o;
    chk("grad_px3", 32'(cap0), 32'h00030303, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
